sonar_scheduler: RTL and testbench

SONAR_SCHEDULER -- requirements
Module: sonar_scheduler

---
 rtl/sonar_scheduler.sv | 161 ++++++++++++++++
 tb/tb_sonar_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/sonar_scheduler.sv
// Periodic sonar measurement scheduler: triggers the sensor, waits for a reply with
// timeout, and confirms a floor after N_CONFIRMA consecutive equal readings.
module sonar_scheduler #(
    parameter int PERIODO    = 5000000,
    parameter int TIMEOUT    = 2500000,
    parameter int N_CONFIRMA = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligado,
    input  logic       pronto,
    input  logic [1:0] andar_medido,
    output logic       medir,
    output logic [1:0] andar,
    output logic       andar_valido,
    output logic       erro_timeout,
    output logic [3:0] db_estado
);

    localparam int CNT_MAX = (PERIODO > TIMEOUT) ? PERIODO : TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        DISPARA = 4'h1,
        AGUARDA = 4'h2,
        AVALIA  = 4'h3,
        ESPERA  = 4'h4,
        ERRO    = 4'hF
    } estado_t;

    estado_t        state_r, next_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [3:0]     conf_r, conf_s, conf_upd_s;
    logic [1:0]     amostra_r, amostra_s, anterior_r, anterior_s;
    logic [1:0]     andar_r, andar_s;
    logic           medir_r, medir_s, valido_r, valido_s, erro_r, erro_s;

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= INICIAL;
        end else begin
            state_r <= next_s;
        end
    end

    // next-state logic; ligado=0 overrides every state
    always_comb begin
        next_s = state_r;
        if (!ligado) begin
            next_s = INICIAL;
        end else begin
            case (state_r)
                INICIAL: next_s = DISPARA;
                DISPARA: next_s = AGUARDA;
                AGUARDA: begin
                    if (pronto) begin
                        next_s = AVALIA;
                    end else if (cnt_r == CW'(TIMEOUT - 1)) begin
                        next_s = ERRO;
                    end else begin
                        next_s = AGUARDA;
                    end
                end
                AVALIA:  next_s = ESPERA;
                ESPERA, ERRO: begin
                    if (cnt_r == CW'(PERIODO - 1)) begin
                        next_s = DISPARA;
                    end else begin
                        next_s = state_r;
                    end
                end
                default: next_s = INICIAL;
            endcase
        end
    end

    // next values of counters, sample registers and registered outputs
    always_comb begin
        medir_s    = (next_s == DISPARA);
        andar_s    = andar_r;
        valido_s   = valido_r;
        erro_s     = erro_r;
        conf_s     = conf_r;
        amostra_s  = amostra_r;
        anterior_s = anterior_r;
        conf_upd_s = 4'd1;
        if (next_s != state_r) begin
            cnt_s = '0;
        end else if (cnt_r != CW'(CNT_MAX)) begin
            cnt_s = cnt_r + CW'(1);
        end else begin
            cnt_s = cnt_r;
        end

        if (amostra_r == anterior_r) begin
            if (conf_r >= 4'(N_CONFIRMA)) begin
                conf_upd_s = 4'(N_CONFIRMA);
            end else begin
                conf_upd_s = conf_r + 4'd1;
            end
        end else begin
            conf_upd_s = 4'd1;
        end

        // ERRO side effects are applied on entry so they line up with db_estado=F
        if (!ligado) begin
            valido_s = 1'b0;
            conf_s   = 4'd0;
        end else if (next_s == ERRO) begin
            erro_s   = 1'b1;
            valido_s = 1'b0;
            conf_s   = 4'd0;
        end else if ((state_r == AGUARDA) && pronto) begin
            amostra_s = andar_medido;
        end else if (state_r == AVALIA) begin
            conf_s     = conf_upd_s;
            anterior_s = amostra_r;
            erro_s     = 1'b0;
            if (conf_upd_s == 4'(N_CONFIRMA)) begin
                andar_s  = amostra_r;
                valido_s = 1'b1;
            end else begin
                andar_s  = andar_r;
            end
        end else begin
            amostra_s = amostra_r;
        end
    end

    // datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_r      <= '0;
            conf_r     <= 4'd0;
            amostra_r  <= 2'd0;
            anterior_r <= 2'd0;
            andar_r    <= 2'd0;
            medir_r    <= 1'b0;
            valido_r   <= 1'b0;
            erro_r     <= 1'b0;
        end else begin
            cnt_r      <= cnt_s;
            conf_r     <= conf_s;
            amostra_r  <= amostra_s;
            anterior_r <= anterior_s;
            andar_r    <= andar_s;
            medir_r    <= medir_s;
            valido_r   <= valido_s;
            erro_r     <= erro_s;
        end
    end

    assign medir        = medir_r;
    assign andar        = andar_r;
    assign andar_valido = valido_r;
    assign erro_timeout = erro_r;
    assign db_estado    = state_r;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with PERIODO=10, TIMEOUT=20, N_CONFIRMA=3;
// expected floor/valid/error results are queued at stimulus time and popped at AVALIA exit.
module tb_sonar_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ligado = 1'b0;
    logic       pronto = 1'b0;
    logic [1:0] andar_medido = 2'd0;
    logic       medir;
    logic [1:0] andar;
    logic       andar_valido;
    logic       erro_timeout;
    logic [3:0] db_estado;

    typedef struct packed {
        logic [1:0] andar;
        logic       valido;
        logic       erro;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;

    sonar_scheduler #(.PERIODO(10), .TIMEOUT(20), .N_CONFIRMA(3)) dut (
        .clock(clock), .reset(reset), .ligado(ligado), .pronto(pronto),
        .andar_medido(andar_medido), .medir(medir), .andar(andar),
        .andar_valido(andar_valido), .erro_timeout(erro_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_medir(input int budget, output int n);
        n = 0;
        while (medir !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("medir_seen", {31'd0, medir}, 32'd1);
    endtask

    // called in a DISPARA cycle; replies 6 cycles later and checks the AVALIA result and period
    task automatic resp(input logic [1:0] r, input logic [1:0] ea, input logic ev, input logic ee);
        int   t0, n;
        exp_t got;
        t0 = cyc;
        step();
        chk("aguarda_state", {28'd0, db_estado}, 32'h2);
        chk("medir_one_cycle", {31'd0, medir}, 32'd0);
        repeat (5) step();
        pronto = 1'b1;
        andar_medido = r;
        step();
        pronto = 1'b0;
        chk("avalia_state", {28'd0, db_estado}, 32'h3);
        sb.push_back('{andar: ea, valido: ev, erro: ee});
        step();
        got = sb.pop_front();
        chk("andar", {30'd0, andar}, {30'd0, got.andar});
        chk("andar_valido", {31'd0, andar_valido}, {31'd0, got.valido});
        chk("erro_timeout", {31'd0, erro_timeout}, {31'd0, got.erro});
        chk("espera_state", {28'd0, db_estado}, 32'h4);
        wait_medir(40, n);
        chk("medir_period", cyc - t0, 32'd18);
    endtask

    initial begin
        int   n, t0;
        exp_t got;

        step();
        step();
        chk("rst_estado", {28'd0, db_estado}, 32'h0);
        chk("rst_medir", {31'd0, medir}, 32'd0);
        chk("rst_andar", {30'd0, andar}, 32'd0);
        chk("rst_valido", {31'd0, andar_valido}, 32'd0);
        chk("rst_erro", {31'd0, erro_timeout}, 32'd0);

        reset = 1'b0;
        step();
        chk("inicial_idle", {28'd0, db_estado}, 32'h0);
        ligado = 1'b1;
        step();
        chk("dispara_state", {28'd0, db_estado}, 32'h1);
        chk("first_medir", {31'd0, medir}, 32'd1);

        resp(2'b10, 2'b00, 1'b0, 1'b0);
        resp(2'b10, 2'b00, 1'b0, 1'b0);
        resp(2'b10, 2'b10, 1'b1, 1'b0);
        resp(2'b01, 2'b10, 1'b1, 1'b0);
        resp(2'b01, 2'b10, 1'b1, 1'b0);
        resp(2'b01, 2'b01, 1'b1, 1'b0);
        resp(2'b11, 2'b01, 1'b1, 1'b0);
        resp(2'b11, 2'b01, 1'b1, 1'b0);
        resp(2'b11, 2'b11, 1'b1, 1'b0);

        // no reply: ERRO after 20 cycles in AGUARDA, retry after 10 more
        repeat (20) step();
        chk("before_timeout", {28'd0, db_estado}, 32'h2);
        step();
        chk("erro_state", {28'd0, db_estado}, 32'hF);
        chk("erro_flag", {31'd0, erro_timeout}, 32'd1);
        chk("erro_valido", {31'd0, andar_valido}, 32'd0);
        chk("erro_andar_kept", {30'd0, andar}, 32'h3);
        wait_medir(30, n);
        chk("retry_gap", n, 32'd10);
        resp(2'b11, 2'b11, 1'b0, 1'b0);

        // pronto on the timeout cycle wins
        t0 = cyc;
        repeat (20) step();
        chk("timeout_cycle_state", {28'd0, db_estado}, 32'h2);
        pronto = 1'b1;
        andar_medido = 2'b11;
        step();
        pronto = 1'b0;
        chk("pronto_wins", {28'd0, db_estado}, 32'h3);
        sb.push_back('{andar: 2'b11, valido: 1'b0, erro: 1'b0});
        step();
        got = sb.pop_front();
        chk("tcy_andar", {30'd0, andar}, {30'd0, got.andar});
        chk("tcy_valido", {31'd0, andar_valido}, {31'd0, got.valido});
        chk("tcy_erro", {31'd0, erro_timeout}, {31'd0, got.erro});
        // stray pronto in ESPERA
        pronto = 1'b1;
        andar_medido = 2'b00;
        step();
        pronto = 1'b0;
        chk("stray_state", {28'd0, db_estado}, 32'h4);
        chk("stray_andar", {30'd0, andar}, 32'h3);
        chk("stray_valido", {31'd0, andar_valido}, 32'd0);
        wait_medir(40, n);
        chk("tcy_period", cyc - t0, 32'd32);
        resp(2'b11, 2'b11, 1'b1, 1'b0);

        // ligado=0 during AGUARDA
        step();
        chk("pre_off_state", {28'd0, db_estado}, 32'h2);
        ligado = 1'b0;
        step();
        chk("off_state", {28'd0, db_estado}, 32'h0);
        chk("off_valido", {31'd0, andar_valido}, 32'd0);
        chk("off_andar_kept", {30'd0, andar}, 32'h3);
        chk("off_medir", {31'd0, medir}, 32'd0);
        ligado = 1'b1;
        step();
        chk("on_dispara", {28'd0, db_estado}, 32'h1);
        step();
        pronto = 1'b1;
        andar_medido = 2'b10;
        step();
        pronto = 1'b0;
        sb.push_back('{andar: 2'b11, valido: 1'b0, erro: 1'b0});
        step();
        got = sb.pop_front();
        chk("reon_andar", {30'd0, andar}, {30'd0, got.andar});
        chk("reon_valido", {31'd0, andar_valido}, {31'd0, got.valido});
        chk("reon_state", {28'd0, db_estado}, 32'h4);

        // async reset mid-ESPERA
        step();
        step();
        #2;
        reset = 1'b1;
        pronto = 1'b1;
        #1;
        chk("async_estado", {28'd0, db_estado}, 32'h0);
        chk("async_andar", {30'd0, andar}, 32'd0);
        chk("async_valido", {31'd0, andar_valido}, 32'd0);
        chk("async_erro", {31'd0, erro_timeout}, 32'd0);
        chk("async_medir", {31'd0, medir}, 32'd0);
        step();
        chk("reset_held", {28'd0, db_estado}, 32'h0);
        reset = 1'b0;
        pronto = 1'b0;
        step();
        chk("post_rst_dispara", {28'd0, db_estado}, 32'h1);
        chk("post_rst_medir", {31'd0, medir}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
